// File: rtl/reaction_time_display.sv
// Reaction-time display stage.
// Converts each accepted binary ms result to 4-digit BCD using a serial
// double-dabble engine (one bit per clock). Holds the last result and
// scans it onto a multiplexed 4-digit 7-segment display, with leading-zero
// blanking and an all-dash overflow indication.
module reaction_time_display #(
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             time_valid,
    input  logic [BIN_W-1:0] time_ms,
    output logic             busy,
    output logic [15:0]      bcd,
    output logic             overflow,
    output logic [6:0]       seg,
    output logic [3:0]       dig_sel
);
    localparam int SR_W  = 16 + BIN_W;
    localparam int BC_W  = $clog2(BIN_W + 1);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [SR_W-1:0]   sr, sr_adj;
    logic [BC_W-1:0]   bit_cnt;
    logic [15:0]       bcd_q;
    logic              ovf_q;
    logic              time_ovf;
    logic [CNT_W-1:0]  ref_cnt;
    logic [1:0]        idx, idx_nxt;
    logic              wrap;
    logic [3:0]        nib;
    logic              blank;
    logic [6:0]        seg_nxt;

    // Zero-extend so the 9999 limit is meaningful for any legal BIN_W.
    assign time_ovf = {{(32-BIN_W){1'b0}}, time_ms} > 32'd9999;
    assign busy     = (state != IDLE);
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: accept only in IDLE, BIN_W shift cycles, one DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (time_valid && !time_ovf) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == BC_W'(BIN_W - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < 4; i++) begin
            if (sr[BIN_W+4*i +: 4] >= 4'd5)
                sr_adj[BIN_W+4*i +: 4] = sr[BIN_W+4*i +: 4] + 4'd3;
        end
    end

    // Conversion datapath and held result; result only moves in DONE or on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
            bcd_q   <= 16'h0000;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (time_valid) begin
                    if (time_ovf) begin
                        ovf_q <= 1'b1;
                        bcd_q <= 16'h9999;
                    end else begin
                        sr      <= {16'h0000, time_ms};
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    sr      <= sr_adj << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                DONE: begin
                    bcd_q <= sr[SR_W-1 -: 16];
                    ovf_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Scan timing: slot counter and digit index.
    assign wrap    = (ref_cnt == CNT_W'(REFRESH_DIV - 1));
    assign idx_nxt = wrap ? idx + 2'd1 : idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt <= '0;
            idx     <= 2'd0;
        end else begin
            ref_cnt <= wrap ? '0 : ref_cnt + 1'b1;
            idx     <= idx_nxt;
        end
    end

    // Segment pattern for the digit that will be enabled next cycle.
    always_comb begin
        nib   = bcd_q[4*idx_nxt +: 4];
        blank = 1'b0;
        case (idx_nxt)
            2'd1:    blank = (bcd_q[15:4] == 12'h000);
            2'd2:    blank = (bcd_q[15:8] == 8'h00);
            2'd3:    blank = (bcd_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
        case (nib)
            4'd0:    seg_nxt = 7'h3F;
            4'd1:    seg_nxt = 7'h06;
            4'd2:    seg_nxt = 7'h5B;
            4'd3:    seg_nxt = 7'h4F;
            4'd4:    seg_nxt = 7'h66;
            4'd5:    seg_nxt = 7'h6D;
            4'd6:    seg_nxt = 7'h7D;
            4'd7:    seg_nxt = 7'h07;
            4'd8:    seg_nxt = 7'h7F;
            4'd9:    seg_nxt = 7'h6F;
            default: seg_nxt = 7'h00;
        endcase
        if (blank) seg_nxt = 7'h00;
        if (ovf_q) seg_nxt = 7'h40;
    end

    // Registered display drive; seg and dig_sel always change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg     <= 7'h3F;
            dig_sel <= 4'b0001;
        end else begin
            seg     <= seg_nxt;
            dig_sel <= 4'b0001 << idx_nxt;
        end
    end
endmodule

// File: tb/tb_reaction_time_display.sv
// Bench for reaction_time_display: arithmetic reference model checked every
// cycle, plus directed vectors with literal expectations.
module tb_reaction_time_display;
    localparam int BIN_W = 14;
    localparam int DIV   = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             time_valid = 1'b0;
    logic [BIN_W-1:0] time_ms = '0;
    logic             busy;
    logic [15:0]      bcd;
    logic             overflow;
    logic [6:0]       seg;
    logic [3:0]       dig_sel;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    reaction_time_display #(.BIN_W(BIN_W), .REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .time_valid(time_valid), .time_ms(time_ms),
        .busy(busy), .bcd(bcd), .overflow(overflow), .seg(seg), .dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_n = 0;
    logic [15:0] m_bcd = 16'h0000;
    logic        m_ovf = 1'b0;
    int          m_pend = 0;
    int          m_val = 0;
    logic [6:0]  m_seg = 7'h3F;
    logic [3:0]  m_dig = 4'b0001;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] b, input logic ovf, input int k);
        logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        int v;
        int p;
        if (ovf) return 7'h40;
        v = b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
        p = (k == 0) ? 1 : (k == 1) ? 10 : (k == 2) ? 100 : 1000;
        if (k > 0 && v < p) return 7'h00;
        return tbl[(v / p) % 10];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n <= 0; m_bcd <= 16'h0000; m_ovf <= 1'b0; m_pend <= 0;
            m_seg <= 7'h3F; m_dig <= 4'b0001;
        end else begin
            m_n   <= m_n + 1;
            m_dig <= 4'b0001 << (((m_n + 1) / DIV) % 4);
            m_seg <= exp_seg(m_bcd, m_ovf, ((m_n + 1) / DIV) % 4);
            if (m_pend > 0) begin
                m_pend <= m_pend - 1;
                if (m_pend == 1) begin
                    m_bcd <= to_bcd(m_val);
                    m_ovf <= 1'b0;
                end
            end else if (time_valid) begin
                if (int'(time_ms) > 9999) begin
                    m_ovf <= 1'b1;
                    m_bcd <= 16'h9999;
                end else begin
                    m_pend <= BIN_W + 1;
                    m_val  <= int'(time_ms);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_busy", int'(busy), int'(m_pend != 0));
            chk("m_bcd", int'(bcd), int'(m_bcd));
            chk("m_ovf", int'(overflow), int'(m_ovf));
            chk("m_seg", int'(seg), int'(m_seg));
            chk("m_dig", int'(dig_sel), int'(m_dig));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic strobe(input int v);
        @(negedge clk);
        time_valid = 1'b1;
        time_ms    = BIN_W'(v);
        @(negedge clk);
        time_valid = 1'b0;
    endtask

    task automatic scan(input string name, input logic [6:0] e0, input logic [6:0] e1,
                        input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < 4; k++) begin
            int t = 0;
            while (dig_sel != (4'b0001 << k) && t < 40) begin
                @(negedge clk);
                t++;
            end
            if (t >= 40) chk({name, "_timeout"}, int'(dig_sel), int'(4'b0001 << k));
            chk(name, int'(seg), int'(e[k]));
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        // 1: reset state
        chk("rst_bcd", int'(bcd), 16'h0000);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dig", int'(dig_sel), 4'b0001);
        chk("rst_seg", int'(seg), 7'h3F);
        scan("rst_scan", 7'h3F, 7'h00, 7'h00, 7'h00);

        // 2: 1234, latency
        strobe(1234);
        chk("t2_busy1", int'(busy), 1);
        repeat (14) @(negedge clk);
        chk("t2_busy15", int'(busy), 1);
        @(negedge clk);
        chk("t2_busy16", int'(busy), 0);
        chk("t2_bcd", int'(bcd), 16'h1234);
        scan("t2_scan", 7'h66, 7'h4F, 7'h5B, 7'h06);

        // 3: overflow then recovery
        strobe(10000);
        chk("t3_ovf", int'(overflow), 1);
        chk("t3_bcd", int'(bcd), 16'h9999);
        chk("t3_busy", int'(busy), 0);
        scan("t3_scan", 7'h40, 7'h40, 7'h40, 7'h40);
        strobe(7);
        repeat (15) @(negedge clk);
        chk("t3_ovf0", int'(overflow), 0);
        chk("t3_bcd7", int'(bcd), 16'h0007);
        scan("t3_scan7", 7'h07, 7'h00, 7'h00, 7'h00);

        // 4: strobe during busy is dropped
        strobe(250);
        @(negedge clk);
        time_valid = 1'b1;
        time_ms    = BIN_W'(999);
        @(negedge clk);
        time_valid = 1'b0;
        repeat (13) @(negedge clk);
        chk("t4_bcd", int'(bcd), 16'h0250);
        repeat (20) @(negedge clk);
        chk("t4_bcd_hold", int'(bcd), 16'h0250);
        chk("t4_busy", int'(busy), 0);

        // 5: reset mid-conversion
        strobe(4321);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_bcd", int'(bcd), 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_bcd_after", int'(bcd), 16'h0000);
        strobe(9999);
        repeat (15) @(negedge clk);
        chk("t5_bcd9999", int'(bcd), 16'h9999);
        chk("t5_ovf", int'(overflow), 0);
        scan("t5_scan", 7'h6F, 7'h6F, 7'h6F, 7'h6F);

        // 6: zero
        strobe(0);
        repeat (15) @(negedge clk);
        chk("t6_bcd", int'(bcd), 16'h0000);
        scan("t6_scan", 7'h3F, 7'h00, 7'h00, 7'h00);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
